// File: rtl/lsu_pipe.sv
// -----------------------------------------------------------------------------
// lsu_pipe -- load/store unit between the execute stage and data memory.
//
// Accepts one memory op at a time from the execute stage, checks its width and
// alignment, and either raises a one-cycle exception pulse (no memory traffic)
// or issues a single word-aligned request to data memory over a valid/ready
// handshake. Store data and byte enables are steered to the addressed byte
// lane. Load data is shifted down from its lane, truncated to the access width
// and sign- or zero-extended. The core stalls on lsu_stall while an access is
// in flight.
//
// Parameters
//   XLEN    data/address width, 32 or 64
//   RD_W    destination register index width
//   STRB_W  byte-enable width, derived from XLEN (do not override)
//
// Ports
//   clk, reset        core clock, synchronous active-high reset
//   req_valid/ready   op handshake from the execute stage
//   req_we            1 = store, 0 = load
//   req_funct3        RISC-V width/sign field
//   req_addr          byte address
//   req_wdata         store data, LSB-aligned
//   req_rd            load destination register
//   mem_req_valid/ready  request handshake to data memory
//   mem_addr          word-aligned address
//   mem_wdata         store data in its byte lane
//   mem_wea           byte write enables, all 0 for loads
//   mem_resp_valid    load data valid from memory
//   mem_rdata         raw memory word
//   ld_valid          one-cycle writeback pulse
//   ld_data, ld_rd    aligned/extended load result and its register
//   exc_valid         one-cycle exception pulse
//   exc_cause         01 load misaligned, 10 store misaligned, 11 illegal width
//   lsu_stall         high whenever an access is in flight
// -----------------------------------------------------------------------------
module lsu_pipe #(
  parameter int XLEN   = 32,
  parameter int RD_W   = 5,
  parameter int STRB_W = XLEN / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  input  logic [RD_W-1:0]   req_rd,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [STRB_W-1:0] mem_wea,
  input  logic              mem_resp_valid,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              ld_valid,
  output logic [XLEN-1:0]   ld_data,
  output logic [RD_W-1:0]   ld_rd,
  output logic              exc_valid,
  output logic [1:0]        exc_cause,
  output logic              lsu_stall
);

  localparam int SFT_W = $clog2(STRB_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam logic [1:0] CAUSE_LD_MISAL = 2'b01;
  localparam logic [1:0] CAUSE_ST_MISAL = 2'b10;
  localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

  state_t r_state;
  state_t w_next_state;

  // Latched op, captured on acceptance of a legal request.
  logic              r_we;
  logic [2:0]        r_funct3;
  logic [SFT_W-1:0]  r_sft;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [STRB_W-1:0] r_wea;
  logic [RD_W-1:0]   r_rd;

  // Result/exception registers driving the pulse outputs.
  logic              r_ld_valid;
  logic [XLEN-1:0]   r_ld_data;
  logic [RD_W-1:0]   r_ld_rd;
  logic              r_exc_valid;
  logic [1:0]        r_exc_cause;

  // Request decode.
  logic              w_accept;
  logic              w_illegal;
  logic              w_misal;
  logic              w_fault;
  logic [1:0]        w_cause;
  logic [7:0]        w_mask8;
  logic [SFT_W-1:0]  w_sft;
  logic [STRB_W-1:0] w_wea;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_word_addr;

  // Load alignment.
  logic [XLEN-1:0]   w_field;
  logic [XLEN-1:0]   w_keep;
  logic              w_sign;
  logic [XLEN-1:0]   w_ld_ext;

  // ---------------------------------------------------------------------------
  // Width / alignment decode of the incoming request
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_illegal = 1'b0;
    w_misal   = 1'b0;
    w_mask8   = 8'h00;
    case (req_funct3)
      3'b000, 3'b100: w_mask8 = 8'h01;
      3'b001, 3'b101: begin
        w_mask8 = 8'h03;
        w_misal = req_addr[0];
      end
      3'b010: begin
        w_mask8 = 8'h0F;
        w_misal = |req_addr[1:0];
      end
      3'b110: begin
        // WU only exists when a word is narrower than the register.
        if (XLEN == 64) begin
          w_mask8 = 8'h0F;
          w_misal = |req_addr[1:0];
        end else begin
          w_illegal = 1'b1;
        end
      end
      3'b011: begin
        if (XLEN == 64) begin
          w_mask8 = 8'hFF;
          w_misal = |req_addr[2:0];
        end else begin
          w_illegal = 1'b1;
        end
      end
      default: w_illegal = 1'b1;
    endcase
  end

  // An illegal width reports as such even if the address is also misaligned.
  assign w_fault = w_illegal | w_misal;
  assign w_cause = w_illegal ? CAUSE_ILLEGAL :
                   (req_we   ? CAUSE_ST_MISAL : CAUSE_LD_MISAL);

  assign w_accept    = (r_state == S_IDLE) && req_valid;
  assign w_sft       = req_addr[SFT_W-1:0];
  // The mask truncation is safe: an 8-byte mask only decodes when XLEN=64.
  assign w_wea       = STRB_W'(w_mask8) << w_sft;
  assign w_wdata     = req_wdata << {w_sft, 3'b000};
  assign w_word_addr = {req_addr[XLEN-1:SFT_W], {SFT_W{1'b0}}};

  // ---------------------------------------------------------------------------
  // Load data alignment: shift the addressed lane down, keep the access width,
  // and fill the upper bits with the sign bit (signed) or zero (unsigned).
  // ---------------------------------------------------------------------------
  assign w_field = mem_rdata >> {r_sft, 3'b000};

  always_comb begin
    w_keep = '1;
    w_sign = 1'b0;
    case (r_funct3)
      3'b000: begin w_keep = XLEN'(8'hFF);         w_sign = w_field[7];  end
      3'b100: begin w_keep = XLEN'(8'hFF);                               end
      3'b001: begin w_keep = XLEN'(16'hFFFF);      w_sign = w_field[15]; end
      3'b101: begin w_keep = XLEN'(16'hFFFF);                            end
      3'b010: begin w_keep = XLEN'(32'hFFFF_FFFF); w_sign = w_field[31]; end
      3'b110: begin w_keep = XLEN'(32'hFFFF_FFFF);                       end
      default: begin w_keep = '1;                                        end
    endcase
  end

  assign w_ld_ext = (w_field & w_keep) | (w_sign ? ~w_keep : '0);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        // Faulting ops are answered with an exception pulse from IDLE.
        if (req_valid && !w_fault) begin
          w_next_state = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          // Stores get no response; loads wait for their data.
          w_next_state = r_we ? S_IDLE : S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  // Memory request fields come from the latched op, so they stay stable for as
  // long as memory back-pressures, and read as zero outside REQ.
  always_comb begin
    req_ready     = 1'b0;
    lsu_stall     = 1'b1;
    mem_req_valid = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_wea       = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        lsu_stall = 1'b0;
      end
      S_REQ: begin
        mem_req_valid = 1'b1;
        mem_addr      = r_addr;
        mem_wdata     = r_wdata;
        mem_wea       = r_wea;
      end
      default: begin
      end
    endcase
  end

  assign ld_valid  = r_ld_valid;
  assign ld_data   = r_ld_data;
  assign ld_rd     = r_ld_rd;
  assign exc_valid = r_exc_valid;
  assign exc_cause = r_exc_cause;

  // ---------------------------------------------------------------------------
  // Op latch, load result and exception registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we        <= 1'b0;
      r_funct3    <= 3'b000;
      r_sft       <= '0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wea       <= '0;
      r_rd        <= '0;
      r_ld_valid  <= 1'b0;
      r_ld_data   <= '0;
      r_ld_rd     <= '0;
      r_exc_valid <= 1'b0;
      r_exc_cause <= 2'b00;
    end else begin
      r_ld_valid  <= 1'b0;
      r_exc_valid <= 1'b0;

      if (w_accept) begin
        if (w_fault) begin
          r_exc_valid <= 1'b1;
          r_exc_cause <= w_cause;
        end else begin
          r_we     <= req_we;
          r_funct3 <= req_funct3;
          r_sft    <= w_sft;
          r_addr   <= w_word_addr;
          r_wdata  <= w_wdata;
          // Loads never write memory.
          r_wea    <= req_we ? w_wea : '0;
          r_rd     <= req_rd;
        end
      end

      if ((r_state == S_WAIT) && mem_resp_valid) begin
        r_ld_valid <= 1'b1;
        r_ld_data  <= w_ld_ext;
        r_ld_rd    <= r_rd;
      end
    end
  end

endmodule

// File: tb/tb_lsu_pipe.sv
module tb_lsu_pipe;

  logic clk;
  logic reset;

  // XLEN=32 instance
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [2:0]  a_req_funct3;
  logic [31:0] a_req_addr, a_req_wdata;
  logic [4:0]  a_req_rd;
  logic        a_mem_req_valid, a_mem_req_ready;
  logic [31:0] a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wea;
  logic        a_mem_resp_valid;
  logic [31:0] a_mem_rdata;
  logic        a_ld_valid;
  logic [31:0] a_ld_data;
  logic [4:0]  a_ld_rd;
  logic        a_exc_valid;
  logic [1:0]  a_exc_cause;
  logic        a_lsu_stall;

  // XLEN=64 instance
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [2:0]  b_req_funct3;
  logic [63:0] b_req_addr, b_req_wdata;
  logic [4:0]  b_req_rd;
  logic        b_mem_req_valid, b_mem_req_ready;
  logic [63:0] b_mem_addr, b_mem_wdata;
  logic [7:0]  b_mem_wea;
  logic        b_mem_resp_valid;
  logic [63:0] b_mem_rdata;
  logic        b_ld_valid;
  logic [63:0] b_ld_data;
  logic [4:0]  b_ld_rd;
  logic        b_exc_valid;
  logic [1:0]  b_exc_cause;
  logic        b_lsu_stall;

  int total = 0;
  int bad   = 0;

  // Event counters sampled on the falling edge, away from the active edge.
  int a_beats = 0, a_lds = 0, a_excs = 0;
  int b_beats = 0, b_lds = 0;
  int mark_beats, mark_lds, mark_excs;

  lsu_pipe #(.XLEN(32)) u_dut32 (
    .clk(clk), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_funct3(a_req_funct3), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .req_rd(a_req_rd),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready),
    .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_wea(a_mem_wea),
    .mem_resp_valid(a_mem_resp_valid), .mem_rdata(a_mem_rdata),
    .ld_valid(a_ld_valid), .ld_data(a_ld_data), .ld_rd(a_ld_rd),
    .exc_valid(a_exc_valid), .exc_cause(a_exc_cause), .lsu_stall(a_lsu_stall)
  );

  lsu_pipe #(.XLEN(64)) u_dut64 (
    .clk(clk), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_funct3(b_req_funct3), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .req_rd(b_req_rd),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready),
    .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_wea(b_mem_wea),
    .mem_resp_valid(b_mem_resp_valid), .mem_rdata(b_mem_rdata),
    .ld_valid(b_ld_valid), .ld_data(b_ld_data), .ld_rd(b_ld_rd),
    .exc_valid(b_exc_valid), .exc_cause(b_exc_cause), .lsu_stall(b_lsu_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (a_mem_req_valid && a_mem_req_ready) a_beats++;
    if (a_ld_valid)  a_lds++;
    if (a_exc_valid) a_excs++;
    if (b_mem_req_valid && b_mem_req_ready) b_beats++;
    if (b_ld_valid)  b_lds++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic a_issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
    a_req_valid  = 1'b1;
    a_req_we     = we;
    a_req_funct3 = f3;
    a_req_addr   = addr;
    a_req_wdata  = wdata;
    a_req_rd     = rd;
  endtask

  task automatic b_issue(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [4:0] rd);
    b_req_valid  = 1'b1;
    b_req_we     = we;
    b_req_funct3 = f3;
    b_req_addr   = addr;
    b_req_wdata  = wdata;
    b_req_rd     = rd;
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 0; a_req_we = 0; a_req_funct3 = 0; a_req_addr = 0; a_req_wdata = 0;
    a_req_rd = 0; a_mem_req_ready = 0; a_mem_resp_valid = 0; a_mem_rdata = 0;
    b_req_valid = 0; b_req_we = 0; b_req_funct3 = 0; b_req_addr = 0; b_req_wdata = 0;
    b_req_rd = 0; b_mem_req_ready = 0; b_mem_resp_valid = 0; b_mem_rdata = 0;

    // ---- Reset state ----
    step(); step();
    check("rst_req_ready", a_req_ready, 1);
    check("rst_stall", a_lsu_stall, 0);
    check("rst_mem_req_valid", a_mem_req_valid, 0);
    check("rst_ld_valid", a_ld_valid, 0);
    check("rst_exc_valid", a_exc_valid, 0);
    check("rst_wea", a_mem_wea, 0);
    check("rst_ld_data", a_ld_data, 0);
    check("rst64_req_ready", b_req_ready, 1);
    reset = 1'b0;
    step();

    // ---- 1: SB to byte lane 3, zero-wait memory ----
    a_mem_req_ready = 1'b1;
    a_issue(1'b1, 3'b000, 32'h4000_0003, 32'h0000_00AB, 5'd0);
    mark_beats = a_beats;
    step();
    a_req_valid = 1'b0;
    check("sb_mem_req_valid", a_mem_req_valid, 1);
    check("sb_wea", a_mem_wea, 4'b1000);
    check("sb_wdata", a_mem_wdata, 32'hAB00_0000);
    check("sb_addr", a_mem_addr, 32'h4000_0000);
    check("sb_req_ready_busy", a_req_ready, 0);
    step();
    check("sb_back_idle", a_lsu_stall, 0);
    check("sb_one_beat", a_beats - mark_beats, 1);

    // ---- SH to upper half: lane steering of a halfword ----
    a_issue(1'b1, 3'b001, 32'h0000_0002, 32'h1234_BEEF, 5'd0);
    step();
    a_req_valid = 1'b0;
    check("sh_wea", a_mem_wea, 4'b1100);
    check("sh_wdata", a_mem_wdata, 32'hBEEF_0000);
    step();

    // ---- 2: LH with 5 wait cycles ----
    a_issue(1'b0, 3'b001, 32'h0000_0002, 32'h0, 5'd7);
    a_mem_rdata = 32'h8001_0000;
    mark_lds = a_lds;
    step();
    a_req_valid = 1'b0;
    check("lh_wea_zero", a_mem_wea, 0);
    step();
    for (int i = 0; i < 5; i++) begin
      check("lh_wait_stall", a_lsu_stall, 1);
      check("lh_wait_no_ld", a_ld_valid, 0);
      step();
    end
    a_mem_resp_valid = 1'b1;
    check("lh_wait_stall_last", a_lsu_stall, 1);
    step();
    a_mem_resp_valid = 1'b0;
    check("lh_ld_valid", a_ld_valid, 1);
    check("lh_ld_data", a_ld_data, 32'hFFFF_8001);
    check("lh_ld_rd", a_ld_rd, 5'd7);
    check("lh_stall_done", a_lsu_stall, 0);
    step();
    check("lh_pulse_ends", a_ld_valid, 0);
    check("lh_one_pulse", a_lds - mark_lds, 1);

    // ---- LHU, zero-wait memory: ld_valid 3 cycles after acceptance ----
    a_issue(1'b0, 3'b101, 32'h0000_0002, 32'h0, 5'd9);
    a_mem_resp_valid = 1'b1;
    step();
    a_req_valid = 1'b0;
    check("lhu_lat1", a_ld_valid, 0);
    step();
    check("lhu_lat2", a_ld_valid, 0);
    step();
    a_mem_resp_valid = 1'b0;
    check("lhu_lat3", a_ld_valid, 1);
    check("lhu_ld_data", a_ld_data, 32'h0000_8001);
    check("lhu_ld_rd", a_ld_rd, 5'd9);
    step();

    // ---- 3: exceptions ----
    mark_beats = a_beats;
    mark_excs  = a_excs;
    a_issue(1'b0, 3'b010, 32'h0000_0001, 32'h0, 5'd1);
    step();
    a_req_valid = 1'b0;
    check("lw_mis_exc", a_exc_valid, 1);
    check("lw_mis_cause", a_exc_cause, 2'b01);
    check("lw_mis_no_req", a_mem_req_valid, 0);
    check("lw_mis_no_stall", a_lsu_stall, 0);
    step();
    check("lw_mis_pulse_ends", a_exc_valid, 0);

    a_issue(1'b1, 3'b001, 32'h0000_0003, 32'h5555, 5'd0);
    step();
    a_req_valid = 1'b0;
    check("sh_mis_exc", a_exc_valid, 1);
    check("sh_mis_cause", a_exc_cause, 2'b10);
    step();

    a_issue(1'b0, 3'b011, 32'h0000_0000, 32'h0, 5'd2);
    step();
    a_req_valid = 1'b0;
    check("ld32_illegal_exc", a_exc_valid, 1);
    check("ld32_illegal_cause", a_exc_cause, 2'b11);
    step();

    a_issue(1'b1, 3'b111, 32'h0000_0001, 32'h0, 5'd0);
    step();
    a_req_valid = 1'b0;
    check("f3_111_cause", a_exc_cause, 2'b11);
    step();
    check("exc_no_beats", a_beats - mark_beats, 0);
    check("exc_count", a_excs - mark_excs, 4);

    // ---- 4: XLEN=64 SD, LWU, LW ----
    b_mem_req_ready = 1'b1;
    b_issue(1'b1, 3'b011, 64'h8, 64'h1122_3344_5566_7788, 5'd0);
    step();
    b_req_valid = 1'b0;
    check("sd_wea", b_mem_wea, 8'hFF);
    check("sd_wdata", b_mem_wdata, 64'h1122_3344_5566_7788);
    check("sd_addr", b_mem_addr, 64'h8);
    step();

    b_issue(1'b0, 3'b110, 64'h4, 64'h0, 5'd3);
    b_mem_rdata      = 64'hF000_0000_0000_0000;
    b_mem_resp_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    check("lwu_addr", b_mem_addr, 64'h0);
    step(); step();
    b_mem_resp_valid = 1'b0;
    check("lwu_ld_valid", b_ld_valid, 1);
    check("lwu_ld_data", b_ld_data, 64'h0000_0000_F000_0000);
    step();

    b_issue(1'b0, 3'b010, 64'h4, 64'h0, 5'd4);
    b_mem_resp_valid = 1'b1;
    step();
    b_req_valid = 1'b0;
    step(); step();
    b_mem_resp_valid = 1'b0;
    check("lw64_ld_data", b_ld_data, 64'hFFFF_FFFF_F000_0000);
    step();

    b_issue(1'b0, 3'b111, 64'h0, 64'h0, 5'd0);
    step();
    b_req_valid = 1'b0;
    check("f3_111_64_exc", b_exc_valid, 1);
    check("f3_111_64_cause", b_exc_cause, 2'b11);
    step();
    check("b_beats_total", b_beats, 3);
    check("b_lds_total", b_lds, 2);

    // ---- 5: back-pressure for 4 cycles ----
    a_mem_req_ready = 1'b0;
    mark_beats = a_beats;
    a_issue(1'b1, 3'b010, 32'h0000_0010, 32'hDEAD_BEEF, 5'd0);
    step();
    a_req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", a_mem_req_valid, 1);
      check("bp_addr", a_mem_addr, 32'h0000_0010);
      check("bp_wea", a_mem_wea, 4'hF);
      check("bp_wdata", a_mem_wdata, 32'hDEAD_BEEF);
      check("bp_req_ready", a_req_ready, 0);
      step();
    end
    check("bp_no_beat_yet", a_beats - mark_beats, 0);
    a_mem_req_ready = 1'b1;
    step();
    check("bp_one_beat", a_beats - mark_beats, 1);
    check("bp_idle", a_req_ready, 1);

    // ---- 6: reset in WAIT, late response ignored ----
    mark_lds  = a_lds;
    mark_excs = a_excs;
    a_issue(1'b0, 3'b010, 32'h0000_0020, 32'h0, 5'd5);
    step();
    a_req_valid = 1'b0;
    step();
    check("rw_in_wait", a_lsu_stall, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rw_idle", a_req_ready, 1);
    a_mem_resp_valid = 1'b1;
    a_mem_rdata      = 32'h1234_5678;
    step();
    a_mem_resp_valid = 1'b0;
    check("rw_no_ld", a_ld_valid, 0);
    check("rw_req_ready", a_req_ready, 1);
    check("rw_stall", a_lsu_stall, 0);
    step();
    check("rw_no_ld_count", a_lds - mark_lds, 0);
    check("rw_no_exc_count", a_excs - mark_excs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
